// File: rtl/eth_fifo_pkg.sv
// Shared types and constants for the switch-port FIFO: word layout and a
// width helper used for pointer and occupancy counters.
package eth_fifo_pkg;

   localparam int ETH_WORD_W = 34;
   localparam int SOP_BIT    = 33;
   localparam int EOP_BIT    = 32;

   typedef logic [ETH_WORD_W-1:0] eth_word_t;

   // Ceiling log2; clog2(1) = 0, clog2(17) = 5.
   function automatic int clog2(input int value);
      int res;
      int v;
      res = 32'sd0;
      v   = value - 32'sd1;
      while (v > 32'sd0) begin
         res = res + 32'sd1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/eth_sync_fifo_if.sv
// Handshake/bus bundle between ingress port logic (master) and the
// eth_sync_fifo (slave).
interface eth_sync_fifo_if #(
   parameter int DATA_WIDTH = eth_fifo_pkg::ETH_WORD_W,
   parameter int DEPTH      = 16
) ();
   import eth_fifo_pkg::*;

   localparam int LW = clog2(DEPTH + 1);

   logic                  flush;
   logic                  wrEnable;
   logic [DATA_WIDTH-1:0] inData;
   logic                  rdEnable;
   logic [DATA_WIDTH-1:0] outData;
   logic                  outValid;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [LW-1:0]         level;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output flush, wrEnable, inData, rdEnable,
      input  outData, outValid, fifo_full, fifo_empty, almost_full,
             almost_empty, level, overflow, underflow
   );

   modport slave (
      input  flush, wrEnable, inData, rdEnable,
      output outData, outValid, fifo_full, fifo_empty, almost_full,
             almost_empty, level, overflow, underflow
   );

endinterface

// File: rtl/eth_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read address.
// Contents are intentionally not reset.
module eth_fifo_ram #(
   parameter int DATA_WIDTH = 34,
   parameter int DEPTH      = 16,
   parameter int AW         = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/eth_sync_fifo.sv
// Synchronous FIFO for the switch port datapath with level, watermark flags,
// sticky error flags and flush. Build option ETH_FIFO_FWFT_EN selects FWFT read.
module eth_sync_fifo
   import eth_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = ETH_WORD_W,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = 12,
   parameter int AE_LEVEL   = 2
) (
   input logic            clk,
   input logic            reset,
   eth_sync_fifo_if.slave bus
);

   localparam int AW = clog2(DEPTH);
   localparam int LW = clog2(DEPTH + 1);

   logic [AW-1:0]         wr_ptr_r;
   logic [AW-1:0]         rd_ptr_r;
   logic [LW-1:0]         level_r;
   logic [LW-1:0]         level_nxt_s;
   logic                  full_r;
   logic                  empty_r;
   logic                  af_r;
   logic                  ae_r;
   logic                  ovf_r;
   logic                  unf_r;
   logic                  wr_acc_s;
   logic                  rd_acc_s;
   logic                  ram_we_s;
   logic [DATA_WIDTH-1:0] ram_rdata_s;

   // Wrap by compare-and-reset so DEPTH need not be a power of two.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1'b1);
   endfunction

   // Accept decisions from registered flags and the resulting next level.
   always_comb begin
      wr_acc_s = bus.wrEnable & ~full_r;
      rd_acc_s = bus.rdEnable & ~empty_r;
      ram_we_s = wr_acc_s & ~bus.flush;
      case ({wr_acc_s, rd_acc_s})
         2'b10:   level_nxt_s = level_r + LW'(1'b1);
         2'b01:   level_nxt_s = level_r - LW'(1'b1);
         default: level_nxt_s = level_r;
      endcase
   end

   eth_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we_s),
      .waddr (wr_ptr_r),
      .wdata (bus.inData),
      .raddr (rd_ptr_r),
      .rdata (ram_rdata_s)
   );

   // Pointers, occupancy, watermark and sticky error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
         af_r     <= 1'b0;
         ae_r     <= 1'b1;
         ovf_r    <= 1'b0;
         unf_r    <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
         af_r     <= 1'b0;
         ae_r     <= 1'b1;
         ovf_r    <= 1'b0;
         unf_r    <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (rd_acc_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         level_r <= level_nxt_s;
         full_r  <= (level_nxt_s == LW'(DEPTH));
         empty_r <= (level_nxt_s == '0);
         af_r    <= (level_nxt_s >= LW'(AF_LEVEL));
         ae_r    <= (level_nxt_s <= LW'(AE_LEVEL));
         if (bus.wrEnable && full_r) begin
            ovf_r <= 1'b1;
         end
         if (bus.rdEnable && empty_r) begin
            unf_r <= 1'b1;
         end
      end
   end

`ifdef ETH_FIFO_FWFT_EN
   assign bus.outData  = ram_rdata_s;
   assign bus.outValid = ~empty_r;
`else
   logic [DATA_WIDTH-1:0] out_data_r;
   logic                  out_valid_r;

   // Registered read: head word captured on the accepting edge, held otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
      end else if (bus.flush) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= rd_acc_s;
         if (rd_acc_s) begin
            out_data_r <= ram_rdata_s;
         end
      end
   end

   assign bus.outData  = out_data_r;
   assign bus.outValid = out_valid_r;
`endif

   assign bus.fifo_full    = full_r;
   assign bus.fifo_empty   = empty_r;
   assign bus.almost_full  = af_r;
   assign bus.almost_empty = ae_r;
   assign bus.level        = level_r;
   assign bus.overflow     = ovf_r;
   assign bus.underflow    = unf_r;

endmodule

// File: tb/tb_eth_sync_fifo.sv
// Self-checking bench for eth_sync_fifo: a queue model checked every cycle on
// two instances (DEPTH 16 and DEPTH 5) plus directed literal expectations.
module tb_eth_sync_fifo;
   import eth_fifo_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   eth_sync_fifo_if #(.DATA_WIDTH(34), .DEPTH(16)) bus0 ();
   eth_sync_fifo_if #(.DATA_WIDTH(34), .DEPTH(5))  bus1 ();

   eth_sync_fifo #(.DATA_WIDTH(34), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)) dut0 (
      .clk(clk), .reset(rst_n), .bus(bus0));
   eth_sync_fifo #(.DATA_WIDTH(34), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut1 (
      .clk(clk), .reset(rst_n), .bus(bus1));

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_on  = 1'b0;

   // Behavioural model: a word queue per instance plus output/sticky state.
   logic [33:0] q0[$];
   logic [33:0] q1[$];
   int          depth_m [2] = '{16, 5};
   int          af_m    [2] = '{12, 4};
   int          ae_m    [2] = '{2, 1};
   logic [33:0] m_data  [2];
   logic        m_valid [2];
   logic        m_ovf   [2];
   logic        m_unf   [2];

   // Inputs as seen by the DUT at each rising edge.
   logic        s_rst;
   logic [1:0]  s_fl, s_we, s_re;
   logic [33:0] s_d0, s_d1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int q_size(input int id);
      return (id == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [33:0] q_head(input int id);
      if (q_size(id) == 0) return 34'h0;
      return (id == 0) ? q0[0] : q1[0];
   endfunction

   task automatic model_reset();
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
         m_data[i] = 34'h0; m_valid[i] = 1'b0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
      end
   endtask

   task automatic model_step(input int id, input logic fl, input logic we,
                             input logic re, input logic [33:0] d);
      int  n;
      bit  full, empty;
      n     = q_size(id);
      full  = (n == depth_m[id]);
      empty = (n == 0);
      if (fl) begin
         if (id == 0) q0.delete(); else q1.delete();
         m_ovf[id] = 1'b0; m_unf[id] = 1'b0; m_valid[id] = 1'b0;
      end else begin
         if (we && full)  m_ovf[id] = 1'b1;
         if (re && empty) m_unf[id] = 1'b1;
         m_valid[id] = 1'b0;
         if (re && !empty) begin
            m_data[id]  = (id == 0) ? q0.pop_front() : q1.pop_front();
            m_valid[id] = 1'b1;
         end
         if (we && !full) begin
            if (id == 0) q0.push_back(d); else q1.push_back(d);
         end
      end
   endtask

   task automatic check_dut(input int id, input logic [33:0] od, input logic ov,
                            input logic ff, input logic fe, input logic af, input logic ae,
                            input int lvl, input logic ovf, input logic unf);
      int n;
      n = q_size(id);
      chk($sformatf("d%0d.level", id), lvl, n);
      chk($sformatf("d%0d.fifo_full", id), ff, (n == depth_m[id]));
      chk($sformatf("d%0d.fifo_empty", id), fe, (n == 0));
      chk($sformatf("d%0d.almost_full", id), af, (n >= af_m[id]));
      chk($sformatf("d%0d.almost_empty", id), ae, (n <= ae_m[id]));
      chk($sformatf("d%0d.overflow", id), ovf, m_ovf[id]);
      chk($sformatf("d%0d.underflow", id), unf, m_unf[id]);
`ifdef ETH_FIFO_FWFT_EN
      chk($sformatf("d%0d.outValid", id), ov, (n != 0));
      if (n != 0) chk($sformatf("d%0d.outData", id), od, q_head(id));
`else
      chk($sformatf("d%0d.outValid", id), ov, m_valid[id]);
      chk($sformatf("d%0d.outData", id), od, m_data[id]);
`endif
   endtask

   always @(posedge clk) begin
      s_rst   <= rst_n;
      s_fl    <= {bus1.flush, bus0.flush};
      s_we    <= {bus1.wrEnable, bus0.wrEnable};
      s_re    <= {bus1.rdEnable, bus0.rdEnable};
      s_d0    <= bus0.inData;
      s_d1    <= bus1.inData;
   end

   // Compare process: advance the model by the last edge, then check both DUTs.
   always @(negedge clk) begin
      if (cmp_on) begin
         if (!rst_n || !s_rst) begin
            model_reset();
         end else begin
            model_step(0, s_fl[0], s_we[0], s_re[0], s_d0);
            model_step(1, s_fl[1], s_we[1], s_re[1], s_d1);
         end
         check_dut(0, bus0.outData, bus0.outValid, bus0.fifo_full, bus0.fifo_empty,
                   bus0.almost_full, bus0.almost_empty, int'(bus0.level),
                   bus0.overflow, bus0.underflow);
         check_dut(1, bus1.outData, bus1.outValid, bus1.fifo_full, bus1.fifo_empty,
                   bus1.almost_full, bus1.almost_empty, int'(bus1.level),
                   bus1.overflow, bus1.underflow);
      end
   end

   task automatic drive(input int id, input logic fl, input logic we,
                        input logic re, input logic [33:0] d);
      bus0.flush = 1'b0; bus0.wrEnable = 1'b0; bus0.rdEnable = 1'b0; bus0.inData = 34'h0;
      bus1.flush = 1'b0; bus1.wrEnable = 1'b0; bus1.rdEnable = 1'b0; bus1.inData = 34'h0;
      if (id == 0) begin
         bus0.flush = fl; bus0.wrEnable = we; bus0.rdEnable = re; bus0.inData = d;
      end else begin
         bus1.flush = fl; bus1.wrEnable = we; bus1.rdEnable = re; bus1.inData = d;
      end
      @(negedge clk);
   endtask

   function automatic logic [33:0] out_d(input int id);
      return (id == 0) ? bus0.outData : bus1.outData;
   endfunction

   function automatic logic out_v(input int id);
      return (id == 0) ? bus0.outValid : bus1.outValid;
   endfunction

   // Pop one word (optionally writing at the same time) and pin its value.
   task automatic pop_expect(input int id, input logic we, input logic [33:0] wd,
                             input logic [33:0] exp);
`ifdef ETH_FIFO_FWFT_EN
      chk("pop_valid", out_v(id), 1'b1);
      chk("pop_data", out_d(id), exp);
      drive(id, 1'b0, we, 1'b1, wd);
`else
      drive(id, 1'b0, we, 1'b1, wd);
      chk("pop_valid", out_v(id), 1'b1);
      chk("pop_data", out_d(id), exp);
`endif
   endtask

   initial begin
      drive(0, 1'b0, 1'b0, 1'b0, 34'h0);
      #2 rst_n = 1'b0;
      cmp_on = 1'b1;
      #1;
      chk("rst_level", bus0.level, 5'd0);
      chk("rst_empty", bus0.fifo_empty, 1'b1);
      chk("rst_almost_empty", bus0.almost_empty, 1'b1);
      chk("rst_full", bus0.fifo_full, 1'b0);
      chk("rst_valid", bus0.outValid, 1'b0);
`ifndef ETH_FIFO_FWFT_EN
      chk("rst_data", bus0.outData, 34'h0);
`endif
      #19 rst_n = 1'b1;
      @(negedge clk);

      for (int i = 1; i <= 16; i++) drive(0, 1'b0, 1'b1, 1'b0, 34'(i));
      chk("fill_level", bus0.level, 5'd16);
      chk("fill_full", bus0.fifo_full, 1'b1);
      chk("fill_almost_full", bus0.almost_full, 1'b1);
      drive(0, 1'b0, 1'b1, 1'b0, 34'h11);
      chk("ovf_set", bus0.overflow, 1'b1);
      chk("ovf_level", bus0.level, 5'd16);

      for (int i = 1; i <= 16; i++) pop_expect(0, 1'b0, 34'h0, 34'(i));
      drive(0, 1'b0, 1'b0, 1'b0, 34'h0);
      chk("drain_empty", bus0.fifo_empty, 1'b1);
      chk("drain_level", bus0.level, 5'd0);
      drive(0, 1'b0, 1'b0, 1'b1, 34'h0);
      chk("unf_set", bus0.underflow, 1'b1);
`ifndef ETH_FIFO_FWFT_EN
      chk("unf_data_hold", bus0.outData, 34'h10);
`endif

      drive(0, 1'b1, 1'b0, 1'b0, 34'h0);
      chk("flush_ovf", bus0.overflow, 1'b0);
      chk("flush_unf", bus0.underflow, 1'b0);

      // Full with read and write together: read wins, write is dropped.
      for (int i = 0; i < 16; i++) drive(0, 1'b0, 1'b1, 1'b0, 34'h21 + 34'(i));
      pop_expect(0, 1'b1, 34'hAA, 34'h21);
      chk("fullrw_level", bus0.level, 5'd15);
      chk("fullrw_ovf", bus0.overflow, 1'b1);
      for (int i = 1; i <= 15; i++) pop_expect(0, 1'b0, 34'h0, 34'h21 + 34'(i));
      drive(0, 1'b0, 1'b0, 1'b0, 34'h0);
      chk("fullrw_no_aa", bus0.fifo_empty, 1'b1);

      for (int i = 0; i < 8; i++) drive(0, 1'b0, 1'b1, 1'b0, 34'h40 + 34'(i));
      chk("pre_flush_level", bus0.level, 5'd8);
      chk("pre_flush_ovf", bus0.overflow, 1'b1);
      drive(0, 1'b1, 1'b1, 1'b0, 34'h55);
      chk("flush_level", bus0.level, 5'd0);
      chk("flush_empty", bus0.fifo_empty, 1'b1);
      chk("flush_ovf2", bus0.overflow, 1'b0);
      drive(0, 1'b0, 1'b0, 1'b0, 34'h0);
      chk("flush_drop_write", bus0.level, 5'd0);

      // DEPTH=5: steady simultaneous traffic across the pointer wrap.
      for (int i = 0; i < 3; i++) drive(1, 1'b0, 1'b1, 1'b0, 34'h101 + 34'(i));
      chk("wrap_level0", bus1.level, 3'd3);
      for (int k = 0; k < 10; k++) begin
         pop_expect(1, 1'b1, 34'h104 + 34'(k), 34'h101 + 34'(k));
         chk("wrap_level", bus1.level, 3'd3);
      end
      for (int k = 0; k < 3; k++) pop_expect(1, 1'b0, 34'h0, 34'h10B + 34'(k));
      drive(1, 1'b0, 1'b0, 1'b0, 34'h0);
      chk("wrap_empty", bus1.fifo_empty, 1'b1);

      // Asynchronous reset in the middle of a write.
      for (int i = 0; i < 3; i++) drive(0, 1'b0, 1'b1, 1'b0, 34'h60 + 34'(i));
      bus0.wrEnable = 1'b1;
      bus0.inData   = 34'h77;
      #3 rst_n = 1'b0;
      #1;
      chk("arst_level", bus0.level, 5'd0);
      chk("arst_empty", bus0.fifo_empty, 1'b1);
      chk("arst_ae", bus0.almost_empty, 1'b1);
      chk("arst_valid", bus0.outValid, 1'b0);
      chk("arst_ovf", bus0.overflow, 1'b0);
`ifndef ETH_FIFO_FWFT_EN
      chk("arst_data", bus0.outData, 34'h0);
`endif
      @(negedge clk);
      bus0.wrEnable = 1'b0;
      bus0.inData   = 34'h0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 1'b1, 34'h0);
      chk("post_rst_unf", bus0.underflow, 1'b1);
      chk("post_rst_valid", bus0.outValid, 1'b0);

      drive(0, 1'b1, 1'b0, 1'b0, 34'h0);
      drive(0, 1'b0, 1'b1, 1'b0, 34'h5);
`ifdef ETH_FIFO_FWFT_EN
      chk("fwft_valid", bus0.outValid, 1'b1);
      chk("fwft_data", bus0.outData, 34'h5);
      drive(0, 1'b0, 1'b0, 1'b1, 34'h0);
      chk("fwft_pop_valid", bus0.outValid, 1'b0);
`else
      drive(0, 1'b0, 1'b0, 1'b1, 34'h0);
      chk("rd5_valid", bus0.outValid, 1'b1);
      chk("rd5_data", bus0.outData, 34'h5);
      drive(0, 1'b0, 1'b0, 1'b0, 34'h0);
      chk("rd5_valid_drop", bus0.outValid, 1'b0);
`endif
      drive(0, 1'b0, 1'b0, 1'b0, 34'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_sync_fifo.md
Name: eth_sync_fifo

Overview:
Parametrised synchronous FIFO for the switch port datapath. It buffers DATA_WIDTH-bit words (default 34 = 32 data + SOP + EOP) between the ingress port logic and the switch arbiter. It supports simultaneous read and write in one cycle, any depth, an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush.

Parameters:
DATA_WIDTH, 34, word width in bits
DEPTH, 16, number of entries; any integer >= 2, not required to be a power of two
AF_LEVEL, 12, almost_full asserts when level >= AF_LEVEL; range 1..DEPTH
AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL; range 0..DEPTH-1

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of contents and error flags
wrEnable  in  1  write request
inData  in  DATA_WIDTH  write data
rdEnable  in  1  read request
outData  out  DATA_WIDTH  read data
outValid  out  1  outData holds a newly popped word (see Behaviour)
fifo_full  out  1  level == DEPTH
fifo_empty  out  1  level == 0
almost_full  out  1  level >= AF_LEVEL
almost_empty  out  1  level <= AE_LEVEL
level  out  LW = clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset: one clock, clk. reset is asynchronous and active-low. While reset=0, outputs take these values: outData=0, outValid=0, fifo_full=0, fifo_empty=1, almost_full=0, almost_empty=1, level=0, overflow=0, underflow=0. Internal wrPtr and rdPtr are 0. Memory contents are not reset.
- Reset mid-operation discards all stored words. The first cycle after release behaves as an empty FIFO.
- Accept rules use registered flags only:
  - A write is accepted iff wrEnable=1 and fifo_full=0.
  - A read is accepted iff rdEnable=1 and fifo_empty=0.
- Simultaneous accepted read and write: both happen in the same cycle and level is unchanged.
- Full with wrEnable=1 and rdEnable=1: the read is accepted and the write is rejected. overflow is set. Level becomes DEPTH-1.
- Empty with both requests: the write is accepted and the read is rejected. underflow is set.
- Pointers increment on accept and wrap from DEPTH-1 to 0. No modulo by a non-power-of-two is allowed in hardware; use compare-and-reset.
- level, fifo_full, fifo_empty, almost_full and almost_empty are all registered and updated from the next level value. They are valid in the cycle after the causing edge.
- Non-FWFT read latency: outData is updated with the head word on the edge that accepts a read. outValid=1 for that one following cycle, otherwise 0. outData holds its value when there is no read.
- overflow and underflow are sticky. They are cleared only by reset or flush.
- flush=1 has priority over wrEnable and rdEnable in the same cycle. On the next edge it sets pointers to 0, level=0, fifo_empty=1, fifo_full=0, overflow=0, underflow=0 and outValid=0. outData holds its value.

Optional Feature:
Macro ETH_FIFO_FWFT_EN.
- Defined: first-word fall-through.
  - outData = mem[rdPtr], read combinationally, and outValid = !fifo_empty.
  - rdEnable acts as a pop or acknowledge.
  - A word written into an empty FIFO appears on outData one cycle after the write edge.
  - outData is don't-care while outValid=0.
- Undefined: registered read as described in Behaviour.
- All other behaviour is identical in both modes.

Decomposition:
- Package eth_fifo_pkg holds:
  - constant ETH_WORD_W=34
  - typedef eth_word_t (logic [33:0])
  - bit-index constants SOP_BIT=33 and EOP_BIT=32
  - function clog2 for level and pointer widths
- One sub-module, eth_fifo_ram: DEPTH x DATA_WIDTH storage with a synchronous write port and an asynchronous read address. It has no reset.
- Pointer, level and flag logic stays in eth_sync_fifo.

Test Plan:
- Fill (defaults, non-FWFT): write 0x1..0x10 on 16 consecutive cycles -> level=16, fifo_full=1 and almost_full=1 after the 16th write. A 17th write of 0x11 -> overflow=1 and the word is not stored.
- Drain and order: from full, read 16 times -> outData sequence 0x1..0x10 with outValid=1 each cycle, then fifo_empty=1, level=0. A 17th read -> underflow=1 and outData stays 0x10.
- Simultaneous and wrap-around: DEPTH=5. Write 3 words, then 10 cycles of simultaneous write and read with incrementing data -> level stays 3 and data order is preserved across the pointer wrap.
- Full plus read and write: at full, assert both requests with inData=0xAA -> the head word is read, level=15, overflow=1, and 0xAA is never read out.
- Flush and reset: with level=8, overflow=1, assert flush together with wrEnable -> level=0, fifo_empty=1, overflow=0, and the write is dropped. Assert reset=0 asynchronously mid-write -> all outputs at reset values before the next edge.
- FWFT (ETH_FIFO_FWFT_EN defined): write 0x5 into an empty FIFO -> next cycle outValid=1 and outData=0x5. Pulse rdEnable -> outValid=0.
